// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg
// Shared types and helpers for the Wishbone N:1 arbiter.
//   arb_state_t : arbiter FSM states (ARB_IDLE, ARB_BUSY)
//   rr_next     : round-robin winner search starting just above the last grant
//   onehot2idx  : one-hot vector to binary index
// Vectors are sized for the largest supported master count (8); callers
// zero-extend narrower request vectors.
package wb_arbiter_pkg;

   localparam int MAX_MASTERS = 8;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // Searches last+1, last+2, ... wrapping at n. Returns last when no request
   // is set; callers gate on |req.
   function automatic logic [2:0] rr_next(input logic [MAX_MASTERS-1:0] req,
                                          input logic [2:0]             last,
                                          input int                     n);
      logic [2:0] win;
      logic       found;
      int         idx;
      win   = last;
      found = 1'b0;
      for (int k = 1; k <= MAX_MASTERS; k++) begin
         idx = int'(last) + k;
         // last < n and k <= n, so a single subtraction wraps correctly
         if (idx >= n) idx = idx - n;
         if (!found && (k <= n) && req[idx[2:0]]) begin
            win   = idx[2:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [2:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_MASTERS; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
// Round-robin arbiter with a grant that is held until the owner releases it.
// Reusable for any shared resource, not only Wishbone.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   i_req       : request vector (one bit per requester)
//   i_release   : owner is done; sampled only while busy
//   o_gnt       : registered one-hot grant, zero while idle
//   o_last      : index of the most recent winner (the owner while busy)
//   o_state     : FSM state (0 = idle, 1 = busy) for debug
// A release is followed by one idle cycle before the next grant.
module wb_rr_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [N-1:0]  i_req,
   input  logic          i_release,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_last,
   output logic          o_state
);

   arb_state_t        r_state;
   logic [N-1:0]      r_gnt;
   logic [IW-1:0]     r_last;
   logic [MAX_MASTERS-1:0] w_req8;
   logic [2:0]        w_win;
   logic [N-1:0]      w_win_oh;

   always_comb begin
      w_req8         = '0;
      w_req8[N-1:0]  = i_req;
      w_win          = rr_next(w_req8, 3'(r_last), N);
      w_win_oh       = '0;
      w_win_oh[w_win[IW-1:0]] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ARB_IDLE;
         r_gnt   <= '0;
         // Start just below master 0 so it has top priority after reset
         r_last  <= IW'(N - 1);
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (|i_req) begin
                  r_gnt   <= w_win_oh;
                  r_last  <= w_win[IW-1:0];
                  r_state <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (i_release) begin
                  r_gnt   <= '0;
                  r_state <= ARB_IDLE;
               end
            end
            default: begin
               r_gnt   <= '0;
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign o_gnt   = r_gnt;
   assign o_last  = r_last;
   assign o_state = r_state;

endmodule

// File: rtl/wb_arbiter_nx1.sv
// wb_arbiter_nx1
// Shares one Wishbone slave port among N_MASTERS masters, round-robin, holding
// each grant for the whole CYC envelope so bursts and RMW stay atomic.
// Ports:
//   clk, rstn                       : clock, asynchronous active-low reset
//   m_cyc/m_stb/m_we                : per-master control
//   m_adr/m_dat_w/m_sel/m_cti/m_bte : packed per-master fields, master i at slice i
//   m_dat_r                         : slave read data, broadcast
//   m_ack/m_err                     : per-master response, only to the owner
//   s_*                             : shared slave port (all zero while idle)
//   gnt                             : registered one-hot grant, zero while idle
// Optional macro WB_ARBITER_TIMEOUT_EN: watchdog that errors the owner's cycle
// after TIMEOUT_CYCLES consecutive stalled strobes.
module wb_arbiter_nx1
   import wb_arbiter_pkg::*;
#(
   parameter int N_MASTERS      = 4,
   parameter int WB_ADDR_WIDTH  = 32,
   parameter int WB_DATA_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic [N_MASTERS-1:0]                 m_cyc,
   input  logic [N_MASTERS-1:0]                 m_stb,
   input  logic [N_MASTERS-1:0]                 m_we,
   input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]   m_adr,
   input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]   m_dat_w,
   input  logic [N_MASTERS*WB_DATA_WIDTH/8-1:0] m_sel,
   input  logic [N_MASTERS*3-1:0]               m_cti,
   input  logic [N_MASTERS*2-1:0]               m_bte,
   output logic [WB_DATA_WIDTH-1:0]             m_dat_r,
   output logic [N_MASTERS-1:0]                 m_ack,
   output logic [N_MASTERS-1:0]                 m_err,
   output logic                                 s_cyc,
   output logic                                 s_stb,
   output logic                                 s_we,
   output logic [WB_ADDR_WIDTH-1:0]             s_adr,
   output logic [WB_DATA_WIDTH-1:0]             s_dat_w,
   output logic [WB_DATA_WIDTH/8-1:0]           s_sel,
   output logic [2:0]                           s_cti,
   output logic [1:0]                           s_bte,
   input  logic [WB_DATA_WIDTH-1:0]             s_dat_r,
   input  logic                                 s_ack,
   input  logic                                 s_err,
   output logic [N_MASTERS-1:0]                 gnt
);

   localparam int AW = WB_ADDR_WIDTH;
   localparam int DW = WB_DATA_WIDTH;
   localparam int SW = WB_DATA_WIDTH / 8;
   localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   if (N_MASTERS < 1 || N_MASTERS > MAX_MASTERS || (DW % 8) != 0 || TIMEOUT_CYCLES < 1)
   begin : g_param_check
      $error("wb_arbiter_nx1: unsupported parameter combination");
   end

   logic [N_MASTERS-1:0] w_gnt;
   logic [IW-1:0]        w_gidx;
   logic                 w_state;
   logic                 w_busy;
   logic                 w_release;
   logic                 w_timeout;

   // While busy the last-winner pointer is the owner's index
   wb_rr_arbiter #(.N(N_MASTERS), .IW(IW)) u_rr (
      .clk       (clk),
      .rstn      (rstn),
      .i_req     (m_cyc),
      .i_release (w_release),
      .o_gnt     (w_gnt),
      .o_last    (w_gidx),
      .o_state   (w_state)
   );

   assign w_busy    = (w_state == ARB_BUSY);
   assign w_release = ~m_cyc[w_gidx];

`ifdef WB_ARBITER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;

   assign w_timeout = w_busy && (r_to_cnt == TW'(TIMEOUT_CYCLES));

   // Counts consecutive strobed cycles without a slave response
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_to_cnt <= '0;
      end else if (!w_busy || w_timeout || !m_stb[w_gidx] || s_ack || s_err) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_adr   = '0;
      s_dat_w = '0;
      s_sel   = '0;
      s_cti   = '0;
      s_bte   = '0;
      if (w_busy) begin
         s_cyc   = m_cyc[w_gidx];
         // The watchdog cycle withdraws the strobe so the slave sees no access
         s_stb   = m_stb[w_gidx] & ~w_timeout;
         s_we    = m_we[w_gidx];
         s_adr   = m_adr[w_gidx*AW +: AW];
         s_dat_w = m_dat_w[w_gidx*DW +: DW];
         s_sel   = m_sel[w_gidx*SW +: SW];
         s_cti   = m_cti[w_gidx*3 +: 3];
         s_bte   = m_bte[w_gidx*2 +: 2];
      end
   end

   // Response routing is combinational so an ACK in the CYC-drop cycle still arrives
   assign m_ack   = {N_MASTERS{s_ack}} & w_gnt;
   assign m_err   = {N_MASTERS{s_err | w_timeout}} & w_gnt;
   assign m_dat_r = s_dat_r;
   assign gnt     = w_gnt;

endmodule

// File: tb/tb_wb_arbiter_nx1.sv
module tb_wb_arbiter_nx1;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [N-1:0]    m_cyc, m_stb, m_we;
   logic [N*AW-1:0] m_adr;
   logic [N*DW-1:0] m_dat_w;
   logic [N*SW-1:0] m_sel;
   logic [N*3-1:0]  m_cti;
   logic [N*2-1:0]  m_bte;
   logic [DW-1:0]   m_dat_r;
   logic [N-1:0]    m_ack, m_err;
   logic            s_cyc, s_stb, s_we;
   logic [AW-1:0]   s_adr;
   logic [DW-1:0]   s_dat_w;
   logic [SW-1:0]   s_sel;
   logic [2:0]      s_cti;
   logic [1:0]      s_bte;
   logic [DW-1:0]   s_dat_r = '0;
   logic            s_ack = 1'b0;
   logic            s_err = 1'b0;
   logic [N-1:0]    gnt;

   wb_arbiter_nx1 #(.N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW),
                    .TIMEOUT_CYCLES(256)) dut (
      .clk(clk), .rstn(rstn),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
      .m_dat_w(m_dat_w), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
      .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
      .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .gnt(gnt)
   );

   // ---------------- per-master stimulus state ----------------
   logic          cyc_a[N], stb_a[N], we_a[N];
   logic [AW-1:0] adr_a[N];
   logic [DW-1:0] dat_a[N];
   logic [SW-1:0] sel_a[N];
   logic [2:0]    cti_a[N];
   logic [1:0]    bte_a[N];
   bit            active[N];
   int            beats_left[N];
   bit            last_ack[N];

   logic [N-1:0]  allowed   = '0;
   int            start_pct = 0;
   int            drop_pct  = 0;
   int            ack_pct   = 0;
   int            err_pct   = 0;
   int            max_beats = 1;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         m_cyc[i]             = cyc_a[i];
         m_stb[i]             = stb_a[i];
         m_we[i]              = we_a[i];
         m_adr[i*AW +: AW]    = adr_a[i];
         m_dat_w[i*DW +: DW]  = dat_a[i];
         m_sel[i*SW +: SW]    = sel_a[i];
         m_cti[i*3 +: 3]      = cti_a[i];
         m_bte[i*2 +: 2]      = bte_a[i];
      end
   end

   // ---------------- scoreboard ----------------
   int           errors = 0;
   int           checks = 0;
   logic [N-1:0] exp_q[$];
   int           grant_log[$];
   int           grant_t[$];
   int           cyc_cnt = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   // Reference model: who owns the bus, from the arbitration rules
   int ref_owner;
   int ref_last;
   int wait_cnt[N];

   always @(posedge clk or negedge rstn) begin : ref_model
      int win;
      if (!rstn) begin
         ref_owner <= -1;
         ref_last  <= N - 1;
         exp_q.delete();
         for (int i = 0; i < N; i++) wait_cnt[i] <= 0;
      end else if (ref_owner < 0) begin
         win = -1;
         for (int k = 1; k <= N; k++) begin
            if (win < 0 && m_cyc[(ref_last + k) % N]) win = (ref_last + k) % N;
         end
         if (win >= 0) begin
            ref_owner <= win;
            ref_last  <= win;
            exp_q.push_back(N'(1) << win);
            // Every waiting requester is served within N grants
            for (int i = 0; i < N; i++) begin
               if (i == win || !m_cyc[i]) wait_cnt[i] <= 0;
               else begin
                  wait_cnt[i] <= wait_cnt[i] + 1;
                  chk("fairness", 128'(wait_cnt[i] + 1 <= N - 1), 128'(1));
               end
            end
         end
      end else if (!m_cyc[ref_owner]) begin
         ref_owner <= -1;
      end
   end

   // Monitor: compares DUT outputs mid-cycle against the model
   logic [N-1:0] prev_gnt = '0;
   always @(negedge clk) begin : monitor
      logic [75:0]  act_s, exp_s;
      logic [N-1:0] exp_g, exp_oh, exp_ack, exp_err;
      cyc_cnt++;
      if (!rstn) begin
         prev_gnt = '0;
         for (int i = 0; i < N; i++) last_ack[i] = 1'b0;
      end else begin
         exp_g = (ref_owner < 0) ? '0 : (N'(1) << ref_owner);
         chk("gnt", 128'(gnt), 128'(exp_g));
         if (prev_gnt == '0 && gnt != '0) begin
            if (exp_q.size() == 0) chk("grant_q_empty", 128'(gnt), 128'(0));
            else begin
               exp_oh = exp_q.pop_front();
               chk("grant_order", 128'(gnt), 128'(exp_oh));
            end
            for (int i = 0; i < N; i++) begin
               if (gnt[i]) begin
                  grant_log.push_back(i);
                  grant_t.push_back(cyc_cnt);
               end
            end
         end
         act_s = {s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, s_cti, s_bte};
         if (ref_owner < 0) exp_s = '0;
         else exp_s = {cyc_a[ref_owner], stb_a[ref_owner], we_a[ref_owner], adr_a[ref_owner],
                       dat_a[ref_owner], sel_a[ref_owner], cti_a[ref_owner], bte_a[ref_owner]};
         chk("slave_mux", 128'(act_s), 128'(exp_s));
         exp_ack = s_ack ? exp_g : '0;
         exp_err = s_err ? exp_g : '0;
         chk("m_ack", 128'(m_ack), 128'(exp_ack));
         chk("m_err", 128'(m_err), 128'(exp_err));
         chk("m_dat_r", 128'(m_dat_r), 128'(s_dat_r));
         for (int i = 0; i < N; i++) last_ack[i] = m_ack[i];
         prev_gnt = gnt;
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         adr_a[i] = $urandom();
         dat_a[i] = $urandom();
         sel_a[i] = SW'($urandom());
         we_a[i]  = 1'($urandom());
         cti_a[i] = 3'($urandom());
         bte_a[i] = 2'($urandom());
         stb_a[i] = ($urandom_range(0, 3) != 0);
         if (!allowed[i]) begin
            active[i] = 1'b0;
            cyc_a[i]  = 1'b0;
         end else if (active[i]) begin
            if (last_ack[i]) beats_left[i]--;
            if (beats_left[i] <= 0 || $urandom_range(0, 99) < drop_pct) begin
               active[i] = 1'b0;
               cyc_a[i]  = 1'b0;
            end
         end else if ($urandom_range(0, 99) < start_pct) begin
            active[i]     = 1'b1;
            cyc_a[i]      = 1'b1;
            beats_left[i] = $urandom_range(1, max_beats);
         end
      end
      s_ack   = ($urandom_range(0, 99) < ack_pct);
      s_err   = ($urandom_range(0, 99) < err_pct);
      s_dat_r = $urandom();
   endtask

   task automatic idle_masters();
      for (int i = 0; i < N; i++) begin
         active[i] = 1'b0; cyc_a[i] = 1'b0; stb_a[i] = 1'b0; we_a[i] = 1'b0;
         adr_a[i] = '0; dat_a[i] = '0; sel_a[i] = '0; cti_a[i] = '0; bte_a[i] = '0;
         beats_left[i] = 0;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      idle_masters();
      // Reset values, with a slave ACK/ERR present to prove they are not routed
      cyc_a[1] = 1'b1; stb_a[1] = 1'b1; adr_a[1] = 32'hdead_beef;
      s_ack = 1'b1; s_err = 1'b1;
      #3;
      chk("rst_gnt", 128'(gnt), 128'(0));
      chk("rst_s_cyc", 128'({s_cyc, s_stb, s_we}), 128'(0));
      chk("rst_s_adr", 128'(s_adr), 128'(0));
      chk("rst_m_ack", 128'(m_ack), 128'(0));
      chk("rst_m_err", 128'(m_err), 128'(0));
      idle_masters();
      s_ack = 1'b0; s_err = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // All four request together, one beat each, slave always acks
      grant_log.delete(); grant_t.delete();
      allowed = '1; start_pct = 100; drop_pct = 0; ack_pct = 100; err_pct = 0; max_beats = 1;
      repeat (20) step();
      begin
         int exp_order[5] = '{0, 1, 2, 3, 0};
         for (int k = 0; k < 5; k++) begin
            chk("rr_order", 128'((grant_log.size() > k) ? grant_log[k] : -1), 128'(exp_order[k]));
         end
         for (int k = 0; k < 4; k++) begin
            chk("rr_bubble", 128'((grant_t.size() > k + 1) ? grant_t[k+1] - grant_t[k] : -1), 128'(3));
         end
      end

      // Randomized traffic: bursts, mid-burst drops, slave errors
      start_pct = 30; drop_pct = 3; ack_pct = 50; err_pct = 6; max_beats = 4;
      repeat (1500) step();

      // Reset in the middle of a granted transfer
      begin
         int t = 0;
         while (gnt == '0 && t < 100) begin
            step();
            t++;
         end
         chk("wait_gnt", 128'(gnt != '0), 128'(1));
      end
      s_ack = 1'b1;
      #2;
      rstn = 1'b0;
      #1;
      chk("async_rst_gnt", 128'(gnt), 128'(0));
      chk("async_rst_s_cyc", 128'(s_cyc), 128'(0));
      chk("async_rst_m_ack", 128'(m_ack), 128'(0));
      allowed = '0;
      idle_masters();
      @(negedge clk);
      rstn = 1'b1;
      grant_log.delete(); grant_t.delete();
      allowed = 4'b0010; start_pct = 100; drop_pct = 0; ack_pct = 100; err_pct = 0; max_beats = 1;
      repeat (4) step();
      chk("post_rst_grant", 128'((grant_log.size() > 0) ? grant_log[0] : -1), 128'(1));

      // More random traffic after the reset
      allowed = '1; start_pct = 40; drop_pct = 2; ack_pct = 40; err_pct = 4; max_beats = 4;
      repeat (1000) step();
      allowed = '0;
      repeat (6) step();
      chk("q_drain", 128'(exp_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
